z_ram_arbiter: RTL

Single-clock arbiter and read sequencer for the 256K x 32 z-vector RAM. The block shares the RAM's single synchronous port between two requesters. The host/loader port issues single-word reads and writes. The stream port fetches a contiguous burst of z words for the Gaussian kernel engine, with ready/valid backpressure. It sits between those two requesters and the RAM instance, and drives the RAM's address, write-enable and write-data inputs directly.

---
 rtl/z_ram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/z_ram_arbiter.sv
// z_ram_arbiter: shares the single synchronous port of the 256K x 32 z-vector
// RAM between a host/loader port (single-word reads and writes) and a stream
// engine that fetches contiguous bursts into a 2-entry output FIFO.
// Handshake: a stream word transfers in any cycle where s_valid and s_ready
// are both high; s_valid depends only on registered state.
module z_ram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_req,
    input  logic        h_we,
    input  logic [17:0] h_addr,
    input  logic [31:0] h_wdata,
    output logic        h_gnt,
    output logic        h_rvalid,
    output logic [31:0] h_rdata,
    input  logic        s_start,
    input  logic [17:0] s_base,
    input  logic [17:0] s_len,
    input  logic        s_ready,
    output logic        s_valid,
    output logic [31:0] s_data,
    output logic        s_busy,
    output logic        s_done,
    output logic [17:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_qin,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [17:0] r_ptr;
    logic [17:0] r_rem;
    logic [17:0] r_addr_hold;
    logic        r_inflight;
    logic        r_last_s;      // 1: stream was granted most recently
    logic        r_h_rvalid;
    logic [31:0] r_buf [0:1];
    logic        r_rd_idx;
    logic        r_wr_idx;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;
    logic        w_credit;
    logic        w_s_req;
    logic        w_h_gnt;
    logic        w_s_gnt;
    logic        w_drained;

    // A stream read issued last cycle lands in the FIFO this cycle, so the
    // occupancy seen by credit includes the in-flight word minus any pop.
    assign w_pop     = (r_count != 2'd0) & s_ready;
    assign w_push    = r_inflight;
    assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit  = (w_occ < 3'd2);
    assign w_s_req   = (r_state == S_RUN) && (r_rem != 18'd0) && w_credit;

    // Round-robin: on conflict the side not granted most recently wins.
    assign w_h_gnt   = h_req & (~w_s_req | r_last_s);
    assign w_s_gnt   = w_s_req & (~h_req | ~r_last_s);

    // Buffer empties by the end of this cycle and nothing is still coming.
    assign w_drained = ~r_inflight & (r_count == {1'b0, w_pop});

    assign h_gnt     = w_h_gnt;
    assign h_rvalid  = r_h_rvalid;
    assign h_rdata   = ram_dout;
    assign s_valid   = (r_count != 2'd0);
    assign s_data    = r_buf[r_rd_idx];
    assign s_busy    = (r_state != S_IDLE);
    assign s_done    = (r_state == S_DONE);

    // RAM address holds its last value when nobody is granted.
    assign ram_addr  = w_h_gnt ? h_addr : (w_s_gnt ? r_ptr : r_addr_hold);
    assign ram_we    = w_h_gnt & h_we;
    assign ram_qin   = (w_h_gnt & h_we) ? h_wdata : 32'd0;

    // Stream engine FSM: burst pointer, remaining count and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 18'd0;
            r_rem   <= 18'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_start) begin
                        r_ptr <= s_base;
                        r_rem <= s_len;
                        if (s_len == 18'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_s_gnt) begin
                        r_ptr <= r_ptr + 18'd1;
                        r_rem <= r_rem - 18'd1;
                        if (r_rem == 18'd1) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Arbitration history, held address, host read-valid and stream in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_s    <= 1'b1;
            r_addr_hold <= 18'd0;
            r_h_rvalid  <= 1'b0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_h_gnt) begin
                r_last_s <= 1'b0;
            end else if (w_s_gnt) begin
                r_last_s <= 1'b1;
            end
            r_addr_hold <= ram_addr;
            r_h_rvalid  <= w_h_gnt & ~h_we;
            r_inflight  <= w_s_gnt;
        end
    end

    // 2-entry output FIFO; push and pop in the same cycle keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0] <= 32'd0;
            r_buf[1] <= 32'd0;
            r_rd_idx <= 1'b0;
            r_wr_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_idx] <= ram_dout;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
